// File: rtl/face_pkg.sv
// Shared definitions for the face frame scheduler: FSM states, default
// geometry and timing, widths of the engine result path.
package face_pkg;

  localparam int unsigned DEF_WIDTH       = 256;
  localparam int unsigned DEF_DEPTH       = 256;
  localparam int unsigned DEF_COLOR_DEPTH = 8;
  localparam int unsigned DEF_TIMEOUT     = 200000;

  localparam int unsigned CENTROID_W  = 8;
  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned NUM_REQ     = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_STREAM   = 3'd2,
    S_DRAIN    = 3'd3,
    S_READOUT  = 3'd4,
    S_CENTROID = 3'd5,
    S_REPORT   = 3'd6
  } state_t;

  // One-hot grant vector for a requester index
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/face_frame_scheduler_if.sv
// Requester-side bundle of the face frame scheduler.
//   req        : per-requester frame request (level, held until grant)
//   srcN_r/g/b : requester N pixel, srcN_valid its valid flag
//   pix_ready  : one-hot, granted requester's pixel consumed this cycle
//   grant      : one-hot engine owner, 0 when idle
// master = requesters, slave = scheduler.
interface face_frame_scheduler_if
  import face_pkg::*;
#(
  parameter int unsigned COLOR_DEPTH = DEF_COLOR_DEPTH
) ();

  logic [NUM_REQ-1:0]     req;
  logic [COLOR_DEPTH-1:0] src0_r;
  logic [COLOR_DEPTH-1:0] src0_g;
  logic [COLOR_DEPTH-1:0] src0_b;
  logic                   src0_valid;
  logic [COLOR_DEPTH-1:0] src1_r;
  logic [COLOR_DEPTH-1:0] src1_g;
  logic [COLOR_DEPTH-1:0] src1_b;
  logic                   src1_valid;
  logic [NUM_REQ-1:0]     pix_ready;
  logic [NUM_REQ-1:0]     grant;

  modport master (
    output req,
    output src0_r, src0_g, src0_b, src0_valid,
    output src1_r, src1_g, src1_b, src1_valid,
    input  pix_ready,
    input  grant
  );

  modport slave (
    input  req,
    input  src0_r, src0_g, src0_b, src0_valid,
    input  src1_r, src1_g, src1_b, src1_valid,
    output pix_ready,
    output grant
  );

endinterface

// File: rtl/face_frame_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   req_i      : request vector
//   load_i     : frame finished; remember its owner
//   owner_i    : index of the requester that owned the finished frame
//   gnt_c      : combinational one-hot grant (0 when no request)
module rr_arbiter2
  import face_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               load_i,
  input  logic               owner_i,
  output logic [NUM_REQ-1:0] gnt_c
);

  // Requester that wins a tie; the one not served last (0 after reset)
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_c = '0;
    case (req_i)
      2'b01:   gnt_c = 2'b01;
      2'b10:   gnt_c = 2'b10;
      2'b11:   gnt_c = idx_to_onehot(prio_q);
      default: gnt_c = '0;
    endcase
  end

  always_comb begin
    prio_d = prio_q;
    if (load_i) prio_d = ~owner_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/face_frame_scheduler.sv
// Arbiter and frame sequencer in front of the skin-detect/centroid engine.
//   clk, rst_n           : clock, async active-low reset
//   src_if (slave)       : requests, two pixel sources, pix_ready, grant
//   fr_enable            : engine start strobe (ARM cycle)
//   fr_r/g/b             : pixel to engine, combinational from granted source
//   fr_finish            : engine readout-phase flag
//   fr_centroid_x/y/done : engine centroid result
//   busy                 : high outside IDLE
//   result_valid/x/y/owner : one-cycle result report, latched centroid
//   underrun             : sticky, a source pixel was missing during STREAM
//   timeout              : one-cycle pulse when a wait state expires
//   frame_count          : completed frames, wrapping
module face_frame_scheduler
  import face_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned COLOR_DEPTH = DEF_COLOR_DEPTH,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  face_frame_scheduler_if.slave  src_if,
  output logic                   fr_enable,
  output logic [COLOR_DEPTH-1:0] fr_r,
  output logic [COLOR_DEPTH-1:0] fr_g,
  output logic [COLOR_DEPTH-1:0] fr_b,
  input  logic                   fr_finish,
  input  logic [CENTROID_W-1:0]  fr_centroid_x,
  input  logic [CENTROID_W-1:0]  fr_centroid_y,
  input  logic                   fr_centroid_done,
  output logic                   busy,
  output logic                   result_valid,
  output logic [CENTROID_W-1:0]  result_x,
  output logic [CENTROID_W-1:0]  result_y,
  output logic                   result_owner,
  output logic                   underrun,
  output logic                   timeout,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int unsigned PIX_N = WIDTH * DEPTH;
  localparam int unsigned PIX_W = $clog2(PIX_N) + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;

  state_t                 state_q, state_d;
  logic [PIX_W-1:0]       pix_cnt_q, pix_cnt_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]     pix_ready_q, pix_ready_d;
  logic                   fr_enable_q, fr_enable_d;
  logic                   busy_q, busy_d;
  logic                   result_valid_q, result_valid_d;
  logic [CENTROID_W-1:0]  result_x_q, result_x_d;
  logic [CENTROID_W-1:0]  result_y_q, result_y_d;
  logic                   result_owner_q, result_owner_d;
  logic                   underrun_q, underrun_d;
  logic                   timeout_q, timeout_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

  logic               owner;
  logic               sel_valid;
  logic               pix_en;
  logic               tmr_expired;
  logic               arb_load;
  logic [NUM_REQ-1:0] arb_gnt_c;

  assign owner       = grant_q[1];
  assign sel_valid   = owner ? src_if.src1_valid : src_if.src0_valid;
  assign tmr_expired = (tmr_q == TMR_W'(TIMEOUT - 1));

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (src_if.req),
    .load_i  (arb_load),
    .owner_i (owner),
    .gnt_c   (arb_gnt_c)
  );

  // Pixel path: the engine cannot stall, so a missing pixel is sent as zero
  assign pix_en = (state_q == S_STREAM) && sel_valid;
  assign fr_r   = pix_en ? (owner ? src_if.src1_r : src_if.src0_r) : '0;
  assign fr_g   = pix_en ? (owner ? src_if.src1_g : src_if.src0_g) : '0;
  assign fr_b   = pix_en ? (owner ? src_if.src1_b : src_if.src0_b) : '0;

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    pix_cnt_d      = pix_cnt_q;
    tmr_d          = tmr_q;
    grant_d        = grant_q;
    result_x_d     = result_x_q;
    result_y_d     = result_y_q;
    result_owner_d = result_owner_q;
    underrun_d     = underrun_q;
    timeout_d      = 1'b0;
    frame_count_d  = frame_count_q;
    arb_load       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (src_if.req != '0) begin
          state_d = S_ARM;
          grant_d = arb_gnt_c;
        end
      end
      S_ARM: begin
        state_d   = S_STREAM;
        pix_cnt_d = '0;
      end
      S_STREAM: begin
        if (!sel_valid) underrun_d = 1'b1;
        if (pix_cnt_q == PIX_W'(PIX_N - 1)) begin
          state_d = S_DRAIN;
          tmr_d   = '0;
        end else begin
          pix_cnt_d = pix_cnt_q + PIX_W'(1);
        end
      end
      S_DRAIN, S_READOUT, S_CENTROID: begin
        if (state_q == S_DRAIN && fr_finish) begin
          state_d = S_READOUT;
          tmr_d   = '0;
        end else if (state_q == S_READOUT && !fr_finish) begin
          state_d = S_CENTROID;
          tmr_d   = '0;
        end else if (state_q == S_CENTROID && fr_centroid_done) begin
          state_d        = S_REPORT;
          result_x_d     = fr_centroid_x;
          result_y_d     = fr_centroid_y;
          result_owner_d = owner;
          frame_count_d  = frame_count_q + FRAME_CNT_W'(1);
        end else if (tmr_expired) begin
          // Abandon the frame; the owner still counts as served
          state_d   = S_IDLE;
          grant_d   = '0;
          timeout_d = 1'b1;
          arb_load  = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_REPORT: begin
        state_d  = S_IDLE;
        grant_d  = '0;
        arb_load = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    // Status outputs follow the state being entered so they line up with it
    fr_enable_d    = (state_d == S_ARM);
    pix_ready_d    = (state_d == S_STREAM) ? grant_d : '0;
    busy_d         = (state_d != S_IDLE);
    result_valid_d = (state_d == S_REPORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pix_cnt_q      <= '0;
      tmr_q          <= '0;
      grant_q        <= '0;
      pix_ready_q    <= '0;
      fr_enable_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_x_q     <= '0;
      result_y_q     <= '0;
      result_owner_q <= 1'b0;
      underrun_q     <= 1'b0;
      timeout_q      <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      pix_cnt_q      <= pix_cnt_d;
      tmr_q          <= tmr_d;
      grant_q        <= grant_d;
      pix_ready_q    <= pix_ready_d;
      fr_enable_q    <= fr_enable_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_x_q     <= result_x_d;
      result_y_q     <= result_y_d;
      result_owner_q <= result_owner_d;
      underrun_q     <= underrun_d;
      timeout_q      <= timeout_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign src_if.grant     = grant_q;
  assign src_if.pix_ready = pix_ready_q;
  assign fr_enable        = fr_enable_q;
  assign busy             = busy_q;
  assign result_valid     = result_valid_q;
  assign result_x         = result_x_q;
  assign result_y         = result_y_q;
  assign result_owner     = result_owner_q;
  assign underrun         = underrun_q;
  assign timeout          = timeout_q;
  assign frame_count      = frame_count_q;

endmodule

// File: doc/face_frame_scheduler.md
Name: face_frame_scheduler

Overview:
- Controller and arbiter placed in front of the single skin-detect/centroid engine (the face reader datapath).
- Grants the engine to one of two pixel requesters (camera path, host/test-pattern path) using round-robin.
- Sequences one frame: arm, stream exactly WIDTH*DEPTH pixels, wait out the engine's readout phase, then latch the centroid.
- Reports the result tagged with its owner, and flags underruns and timeouts.

Parameters:
- WIDTH, 256, pixels per line fed to the engine
- DEPTH, 256, lines per frame
- COLOR_DEPTH, 8, bits per colour channel
- TIMEOUT, 200000, max cycles allowed in each wait state (DRAIN, READOUT, CENTROID)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  2  frame request per requester; level, held until grant
- src0_r, src0_g, src0_b  in  COLOR_DEPTH each  requester 0 pixel
- src0_valid  in  1  requester 0 pixel valid
- src1_r, src1_g, src1_b  in  COLOR_DEPTH each  requester 1 pixel
- src1_valid  in  1  requester 1 pixel valid
- pix_ready  out  2  one-hot; granted requester's pixel is consumed this cycle
- grant  out  2  one-hot owner of the engine; 0 when idle
- fr_enable  out  1  engine start strobe
- fr_r, fr_g, fr_b  out  COLOR_DEPTH each  pixel to engine
- fr_finish  in  1  engine readout-phase flag
- fr_centroid_x, fr_centroid_y  in  8 each  engine centroid
- fr_centroid_done  in  1  engine centroid valid
- busy  out  1  high in every state except IDLE
- result_valid  out  1  one-cycle pulse with the result
- result_x, result_y  out  8 each  latched centroid
- result_owner  out  1  index of the requester that owned the frame
- underrun  out  1  sticky; set if valid was low during STREAM
- timeout  out  1  one-cycle pulse when a wait state expires
- frame_count  out  16  completed frames, wraps at 0xFFFF→0

Behaviour:
- Reset values: all outputs 0, state IDLE, rr pointer 0.
- States: IDLE, ARM, STREAM, DRAIN, READOUT, CENTROID, REPORT.
- IDLE: arbitrate when req≠0.
  - Only one requester asserted: grant it.
  - Both asserted: grant the requester not served last (rr pointer; requester 0 first after reset).
  - Grant registers on the transition to ARM.
- ARM: exactly one cycle; fr_enable=1; grant stays held through REPORT.
- STREAM: exactly WIDTH*DEPTH cycles, starting the cycle after ARM.
  - Pixel k goes to the engine in STREAM cycle k (first pixel 2 cycles after the grant decision).
  - pix_ready[owner]=1 throughout STREAM; the fr_* pixel path is combinational from the granted source.
  - Source valid low in any STREAM cycle: drive fr_* with 0, set underrun (sticky until reset), keep counting. The engine cannot stall.
  - Pixel counter width: clog2(WIDTH*DEPTH)+1. Go to DRAIN after count reaches WIDTH*DEPTH-1.
- DRAIN: wait for fr_finish=1, then go to READOUT.
- READOUT: wait for fr_finish=0, then go to CENTROID.
- CENTROID: wait for fr_centroid_done=1.
  - Latch fr_centroid_x/y into result_x/y on that cycle.
  - If done is already high on entry, latch immediately.
- REPORT: one cycle.
  - result_valid=1, result_owner=owner.
  - frame_count+1, rr pointer=owner.
  - Then IDLE with grant=0.
- Timeout: a single counter clears on entry to DRAIN, READOUT and CENTROID.
  - Reaching TIMEOUT pulses timeout for 1 cycle and returns to IDLE.
  - No result_valid; frame_count unchanged; rr pointer still advances.
- req dropped after grant: ignored; the frame completes.
- fr_finish or fr_centroid_done while in IDLE/ARM/STREAM: ignored.
- rst_n low in any state: immediate return to IDLE and all outputs 0. The engine is not reset by this block, so software must allow one engine frame time before the next request.
- result_x/y hold their value until the next REPORT.

Decomposition:
- Shared package face_pkg: state encoding constants, default WIDTH/DEPTH/COLOR_DEPTH, TIMEOUT default.
- One natural sub-module: rr_arbiter2, a 2-way round-robin with a last-owner register, combinational grant and a registered update on load.

Test Plan:
- WIDTH=DEPTH=4, req=01, src0_valid always 1: fr_enable 1 cycle, pix_ready[0] high exactly 16 cycles. With a behavioural engine model giving centroid (2,1): result_valid once, result_x=2, result_y=1, owner=0, frame_count=1.
- req=11 held for three frames: grant sequence 0,1,0. result_owner matches each; no overlap of grant bits.
- src1_valid low on STREAM cycle 5 only: fr_r/g/b=0 that cycle; underrun=1 and stays 1; frame still reports.
- Engine model never raises fr_finish, TIMEOUT=50: timeout pulses at DRAIN entry+50; back to IDLE; result_valid never asserts; frame_count unchanged.
- rst_n asserted mid-STREAM (cycle 7): outputs 0 asynchronously, state IDLE. After release with req=10, requester 1 is granted first.
- fr_centroid_done already high when entering CENTROID: result latched on the entry cycle; REPORT on the next cycle.
